a5_burst_ctrl: RTL and testbench
================================

A5_BURST_CTRL -- requirements
Module: a5_burst_ctrl

Interface
REQ-001 One clock; reset is synchronous and active-high.
REQ-002 Clk  in  1  rising-edge clock for the whole block.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Start  in  1  one-cycle request to generate keystream for the current Kc/Fn.
REQ-005 Kc  in  64  session key; byte i = Kc[8i+7:8i], sent LSB first, byte 0 first.
REQ-006 Fn  in  22  frame number; sent Fn[0] first.
REQ-007 Busy  out  1  high from the cycle after Start is accepted until Done.
REQ-008 Done  out  1  one-cycle pulse when Ks_dl and Ks_ul are valid.
REQ-009 Error  out  1  one-cycle pulse on a core keying timeout.
REQ-010 Ks_dl  out  114  first 114 keystream bits; bit 0 is the earliest.
REQ-011 Ks_ul  out  114  next 114 keystream bits; bit 0 is the earliest.
REQ-012 Core_Reset_n  out  1  active-low reset to the a5 core.
REQ-013 Core_Startloading  out  1  core load strobe.
REQ-014 Core_Keybit  out  1  serial key and frame bit to the core.
REQ-015 Core_Bitout  in  1  core keystream bit.
REQ-016 Core_Doneloading  in  1  core keying-complete flag.

Function
REQ-017 FSM states: IDLE, CRST, START, LOADKEY, LOADFN, WAITDONE, COLLECT, FIN.
REQ-018 IDLE: Start=1 latches Kc and Fn into shadow registers and enters CRST; Start in any other state is ignored.
REQ-019 CRST: lasts one cycle with Core_Reset_n=0, then enters START.
REQ-020 START (cycle c): Core_Startloading=1 for exactly one cycle; Core_Startloading=0 in all other cycles.
REQ-021 LOADKEY: occupies cycles c+1..c+64 and drives Kc[k] in cycle c+1+k.
REQ-022 LOADFN: occupies cycles c+65..c+86 and drives Fn[k] in cycle c+65+k.
REQ-023 Core_Keybit=0 outside LOADKEY and LOADFN.
REQ-024 A 7-bit counter sequences LOADKEY (0..63), LOADFN (0..21) and WAITDONE, and clears on every state change.
REQ-025 WAITDONE: the first cycle with Core_Doneloading=1 enters COLLECT and that same cycle's Core_Bitout is captured as bit 0.
REQ-026 WAITDONE timeout: if Core_Doneloading is not seen within 120 cycles, pulse Error, drive Core_Reset_n=0 for one cycle, and return to IDLE; Ks_dl and Ks_ul are left unchanged.
REQ-027 COLLECT: captures one bit per cycle, 228 bits total, using an 8-bit index 0..227.
REQ-028 Capture mapping: index 0..113 goes to Ks_dl[index]; index 114..227 goes to Ks_ul[index-114].
REQ-029 FIN: pulses Done for one cycle, drives Core_Reset_n=0 for that cycle to park the core, and returns to IDLE.
REQ-030 Nominal timing: Start in cycle 0 gives CRST in cycle 1 and Core_Startloading in cycle 2.
REQ-031 Nominal timing: Core_Doneloading is first seen in cycle c+189 and Done is high in cycle 419.
REQ-032 Ks_dl and Ks_ul hold their values until overwritten by the next successful run.
REQ-033 During COLLECT, partially updated Ks_dl/Ks_ul bits are visible; consumers qualify on Done.
REQ-034 Start in the same cycle as Done or Error is ignored; a new Start is accepted from IDLE in the following cycle.
REQ-035 Core_Doneloading dropping during COLLECT is ignored; collection continues for the full 228 bits.

Reset
REQ-036 Reset=1 forces IDLE and clears counters, shadow registers, Ks_dl, Ks_ul, Busy, Done, Error, Core_Startloading and Core_Keybit.
REQ-037 Core_Reset_n=0 while Reset=1.
REQ-038 Reset asserted mid-run aborts the run at the next edge with no Done and no Error; the first accepted Start afterwards restarts from CRST.

Structure
REQ-039 A shared package a5_pkg holds the FSM state enum and these constants: KEY_BITS=64, FN_BITS=22, BLK_BITS=114, KS_BITS=228, DONE_TIMEOUT=120.
REQ-040 One sub-module, a5_ks_deser, holds the 228-bit capture register and index logic (inputs bit, enable, clear; outputs both blocks).
REQ-041 The a5 core is instantiated by the parent, not inside this block.

Verification
REQ-042 Bench pairs the block with the a5 core; Kc bytes 12,23,45,67,89,AB,CD,EF, Fn=0x134, Start in cycle 0 -> Done in cycle 419, no Error, and Ks_dl[31:0] matches the published C model's first 32 bits (known-good 0x534EAA58 in time order).
REQ-043 Core_Keybit trace for the REQ-042 run -> cycles 3..10 show 0,1,0,0,1,0,0,0 (byte 0x12 LSB first); cycles 67..88 show Fn 0x134 LSB first.
REQ-044 Core model that never raises Core_Doneloading -> Error pulse 120 cycles into WAITDONE, Core_Reset_n low one cycle, Busy low, Ks_dl and Ks_ul unchanged.
REQ-045 Start repeated every cycle for 500 cycles -> exactly one run, Done in cycle 419, then a second run accepted in cycle 420 whose Done falls in cycle 839.
REQ-046 Reset asserted in cycle 200 (COLLECT) -> no Done, all outputs zero next cycle; Start in cycle 205 -> Done in cycle 624 with the same Ks_dl and Ks_ul as REQ-042.

Source files
------------

// File: rtl/a5_pkg.sv
// Shared definitions for the A5 burst controller.
// Holds the controller state encoding and the key/frame/keystream sizing
// constants used by the controller and its keystream deserializer.
package a5_pkg;

  localparam int unsigned KEY_BITS     = 64;
  localparam int unsigned FN_BITS      = 22;
  localparam int unsigned BLK_BITS     = 114;
  localparam int unsigned KS_BITS      = 228;
  localparam int unsigned DONE_TIMEOUT = 120;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    START,
    LOADKEY,
    LOADFN,
    WAITDONE,
    COLLECT,
    FIN
  } state_e;

endpackage

// File: rtl/a5_ks_deser.sv
// Keystream deserializer: shifts the core's serial keystream into the
// downlink (first 114 bits) and uplink (next 114 bits) blocks.
// Ports:
//   clk, rst      - clock and synchronous active-high reset (clears all)
//   bit_in        - serial keystream bit from the core
//   enable        - capture bit_in at the current index and advance it
//   clear         - rewind the index to 0 (blocks keep their contents)
//   ks_dl, ks_ul  - captured blocks, bit 0 is the earliest bit
//   last          - high in the cycle that captures the final bit
module a5_ks_deser
  import a5_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_in,
  input  logic                enable,
  input  logic                clear,
  output logic [BLK_BITS-1:0] ks_dl,
  output logic [BLK_BITS-1:0] ks_ul,
  output logic                last
);

  logic [7:0]          idx_q, idx_d;
  logic [BLK_BITS-1:0] dl_q, dl_d;
  logic [BLK_BITS-1:0] ul_q, ul_d;
  logic [6:0]          ul_idx;

  always_comb begin
    idx_d  = idx_q;
    dl_d   = dl_q;
    ul_d   = ul_q;
    ul_idx = 7'(idx_q - 8'(BLK_BITS));
    if (clear) begin
      idx_d = '0;
    end else if (enable) begin
      if (idx_q < 8'(BLK_BITS)) begin
        dl_d[idx_q[6:0]] = bit_in;
      end else if (idx_q < 8'(KS_BITS)) begin
        ul_d[ul_idx] = bit_in;
      end
      idx_d = idx_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      dl_q  <= '0;
      ul_q  <= '0;
    end else begin
      idx_q <= idx_d;
      dl_q  <= dl_d;
      ul_q  <= ul_d;
    end
  end

  assign ks_dl = dl_q;
  assign ks_ul = ul_q;
  assign last  = enable && !clear && (idx_q == 8'(KS_BITS - 1));

endmodule

// File: rtl/a5_burst_ctrl.sv
// A5 burst controller: on Start, keys an external A5 core with Kc (64 bits,
// LSB of byte 0 first) and Fn (22 bits, Fn[0] first), waits for the core to
// finish keying, then collects 228 keystream bits into Ks_dl / Ks_ul.
// Ports:
//   Clk, Reset          - clock, synchronous active-high reset
//   Start, Kc, Fn       - run request and its key / frame number
//   Busy, Done, Error   - run in progress, success pulse, keying timeout pulse
//   Ks_dl, Ks_ul        - downlink / uplink keystream blocks (bit 0 earliest)
//   Core_Reset_n, Core_Startloading, Core_Keybit  - drive to the A5 core
//   Core_Bitout, Core_Doneloading                 - returns from the A5 core
module a5_burst_ctrl
  import a5_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [KEY_BITS-1:0] Kc,
  input  logic [FN_BITS-1:0]  Fn,
  output logic                Busy,
  output logic                Done,
  output logic                Error,
  output logic [BLK_BITS-1:0] Ks_dl,
  output logic [BLK_BITS-1:0] Ks_ul,
  output logic                Core_Reset_n,
  output logic                Core_Startloading,
  output logic                Core_Keybit,
  input  logic                Core_Bitout,
  input  logic                Core_Doneloading
);

  state_e              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [KEY_BITS-1:0] kc_q, kc_d;
  logic [FN_BITS-1:0]  fn_q, fn_d;
  logic                error_q, error_d;
  logic                cap_en, cap_clr, cap_last;

  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    fn_d    = fn_q;
    error_d = 1'b0;
    cap_en  = 1'b0;
    cap_clr = 1'b0;
    case (state_q)
      // A Start coinciding with the Error pulse (state already IDLE) is dropped.
      IDLE: begin
        if (Start && !error_q) begin
          kc_d    = Kc;
          fn_d    = Fn;
          state_d = CRST;
        end
      end
      CRST: begin
        cap_clr = 1'b1;
        state_d = START;
      end
      START: state_d = LOADKEY;
      LOADKEY: begin
        if (cnt_q == 7'(KEY_BITS - 1)) state_d = LOADFN;
      end
      LOADFN: begin
        if (cnt_q == 7'(FN_BITS - 1)) state_d = WAITDONE;
      end
      // The cycle that first shows Doneloading already carries keystream bit 0.
      WAITDONE: begin
        if (Core_Doneloading) begin
          cap_en  = 1'b1;
          state_d = COLLECT;
        end else if (cnt_q == 7'(DONE_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      COLLECT: begin
        cap_en = 1'b1;
        if (cap_last) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == LOADKEY || state_q == LOADFN || state_q == WAITDONE) begin
      cnt_d = cnt_q + 7'd1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kc_q    <= '0;
      fn_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kc_q    <= kc_d;
      fn_q    <= fn_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    Core_Keybit = 1'b0;
    case (state_q)
      LOADKEY: Core_Keybit = kc_q[cnt_q[5:0]];
      LOADFN:  Core_Keybit = fn_q[cnt_q[4:0]];
      default: Core_Keybit = 1'b0;
    endcase
  end

  assign Busy              = (state_q != IDLE);
  assign Done              = (state_q == FIN);
  assign Error             = error_q;
  assign Core_Startloading = (state_q == START);
  // Core is held in reset during our reset, before keying, and after each run ends.
  assign Core_Reset_n      = !(Reset || state_q == CRST || state_q == FIN || error_q);

  a5_ks_deser u_deser (
    .clk    (Clk),
    .rst    (Reset),
    .bit_in (Core_Bitout),
    .enable (cap_en),
    .clear  (cap_clr),
    .ks_dl  (Ks_dl),
    .ks_ul  (Ks_ul),
    .last   (cap_last)
  );

endmodule

// File: tb/tb_a5_burst_ctrl.sv
// Bench for a5_burst_ctrl paired with a cycle-level A5/1 core model.
// Expected keystreams come from an independent reference computation of A5/1.
module tb_a5_burst_ctrl;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [63:0]   Kc = '0;
  logic [21:0]   Fn = '0;
  logic          Busy, Done, Error;
  logic [113:0]  Ks_dl, Ks_ul;
  logic          Core_Reset_n, Core_Startloading, Core_Keybit;
  logic          Core_Bitout, Core_Doneloading;

  always #5 Clk = ~Clk;

  a5_burst_ctrl dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Start             (Start),
    .Kc                (Kc),
    .Fn                (Fn),
    .Busy              (Busy),
    .Done              (Done),
    .Error             (Error),
    .Ks_dl             (Ks_dl),
    .Ks_ul             (Ks_ul),
    .Core_Reset_n      (Core_Reset_n),
    .Core_Startloading (Core_Startloading),
    .Core_Keybit       (Core_Keybit),
    .Core_Bitout       (Core_Bitout),
    .Core_Doneloading  (Core_Doneloading)
  );

  localparam logic [63:0] REF_KC = 64'hEFCDAB8967452312;
  localparam logic [21:0] REF_FN = 22'h134;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // One A5/1 step; state packs R1[18:0], R2[40:19], R3[63:41].
  function automatic logic [63:0] a5_step(input logic [63:0] s, input bit load, input logic b);
    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic        maj;
    r1  = s[18:0];
    r2  = s[40:19];
    r3  = s[63:41];
    maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
    if (load || r1[8] == maj) r1 = {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13]};
    if (load || r2[10] == maj) r2 = {r2[20:0], r2[21] ^ r2[20]};
    if (load || r3[10] == maj) r3 = {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7]};
    if (load) begin
      r1[0] = r1[0] ^ b;
      r2[0] = r2[0] ^ b;
      r3[0] = r3[0] ^ b;
    end
    return {r3, r2, r1};
  endfunction

  function automatic void a5_ref(input logic [63:0] kc, input logic [21:0] fn,
                                 output logic [113:0] dl, output logic [113:0] ul);
    logic [63:0] s;
    s  = '0;
    dl = '0;
    ul = '0;
    for (int i = 0; i < 64; i++) s = a5_step(s, 1'b1, kc[i]);
    for (int i = 0; i < 22; i++) s = a5_step(s, 1'b1, fn[i]);
    for (int i = 0; i < 100; i++) s = a5_step(s, 1'b0, 1'b0);
    for (int i = 0; i < 228; i++) begin
      s = a5_step(s, 1'b0, 1'b0);
      if (i < 114) dl[i] = s[18] ^ s[40] ^ s[63];
      else         ul[i - 114] = s[18] ^ s[40] ^ s[63];
    end
  endfunction

  // Core model: Startloading in cycle c, keybits c+1..c+86, 100 mixing
  // clocks, Doneloading with keystream bit 0 first visible in cycle c+189.
  logic [63:0] ms;
  int          mk;
  logic        mdone;
  bit          core_dead = 1'b0;

  always @(posedge Clk) begin
    if (!Core_Reset_n) begin
      ms <= '0; mk <= 0; mdone <= 1'b0;
    end else if (Core_Startloading) begin
      ms <= '0; mk <= 1; mdone <= 1'b0;
    end else if (mk > 0) begin
      mk <= mk + 1;
      if (mk <= 86) ms <= a5_step(ms, 1'b1, Core_Keybit);
      else if (mk <= 186) ms <= a5_step(ms, 1'b0, 1'b0);
      else if (mk >= 188 && !core_dead) begin
        ms    <= a5_step(ms, 1'b0, 1'b0);
        mdone <= 1'b1;
      end
    end
  end

  assign Core_Doneloading = mdone;
  assign Core_Bitout      = ms[18] ^ ms[40] ^ ms[63];

  typedef struct {
    int           cyc;
    bit           err;
    logic [113:0] dl;
    logic [113:0] ul;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [63:0] kc;
    logic [21:0] fn;
    bit          dead;
    int          evt_cyc;
    bit          golden_en;
    logic [31:0] golden;
  } vec_t;

  logic [113:0] last_dl = '0;
  logic [113:0] last_ul = '0;
  logic         trace_kb [2048];
  logic         trace_sl [2048];
  logic         trace_rn [2048];

  function automatic void chk(input string name, input logic [227:0] act, input logic [227:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic observe();
    sb_t e;
    if (cyc < 2048) begin
      trace_kb[cyc] = Core_Keybit;
      trace_sl[cyc] = Core_Startloading;
      trace_rn[cyc] = Core_Reset_n;
    end
    if (Done === 1'b1 || Error === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: Done=%b Error=%b at cycle %0d, none expected", Done, Error, cyc);
      end else begin
        e = sb.pop_front();
        chk("event_cycle", 228'(cyc), 228'(e.cyc));
        chk("done_flag", 228'(Done), 228'(!e.err));
        chk("error_flag", 228'(Error), 228'(e.err));
        chk("ks_dl", 228'(Ks_dl), 228'(e.dl));
        chk("ks_ul", 228'(Ks_ul), 228'(e.ul));
        chk("event_core_reset_n", 228'(Core_Reset_n), 228'(0));
        if (e.err) chk("error_busy", 228'(Busy), 228'(0));
      end
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    cyc++;
    observe();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL wait_budget: %0d events still pending at cycle %0d, required 0", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input bit trace_check);
    sb_t         e;
    logic [7:0]  kb;
    logic [21:0] fb;
    logic [31:0] head;
    logic        stray;
    int          sl_cnt;
    Kc        = v.kc;
    Fn        = v.fn;
    core_dead = v.dead;
    if (v.dead) begin
      e.dl = last_dl;
      e.ul = last_ul;
    end else begin
      a5_ref(v.kc, v.fn, e.dl, e.ul);
      last_dl = e.dl;
      last_ul = e.ul;
    end
    e.err = v.dead;
    e.cyc = v.evt_cyc;
    sb.push_back(e);
    cyc   = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("busy_after_start", 228'(Busy), 228'(1));
    drain(1000);
    // Start in the Done/Error cycle must not launch a run.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_on_event_ignored", 228'(Busy), 228'(0));
    if (v.golden_en) begin
      for (int i = 0; i < 32; i++) head[i] = v.golden[31 - i];
      chk("golden_ks_dl_head", 228'(Ks_dl[31:0]), 228'(head));
    end
    if (trace_check) begin
      for (int k = 0; k < 8; k++)  kb[k] = trace_kb[3 + k];
      for (int k = 0; k < 22; k++) fb[k] = trace_kb[67 + k];
      chk("keybit_byte0", 228'(kb), 228'(8'h12));
      chk("keybit_fn", 228'(fb), 228'(REF_FN));
      stray  = 1'b0;
      sl_cnt = 0;
      for (int k = 0; k <= 419; k++) begin
        if ((k < 3 || k > 88) && trace_kb[k] === 1'b1) stray = 1'b1;
        if (trace_sl[k] === 1'b1) sl_cnt++;
      end
      chk("keybit_idle_zero", 228'(stray), 228'(0));
      chk("startloading_count", 228'(sl_cnt), 228'(1));
      chk("startloading_cycle2", 228'(trace_sl[2]), 228'(1));
      chk("crst_core_reset_n", 228'(trace_rn[1]), 228'(0));
      chk("start_core_reset_n", 228'(trace_rn[2]), 228'(1));
    end
  endtask

  vec_t vecs[6];
  sb_t  e2;

  initial begin
    vecs[0] = '{kc: REF_KC, fn: REF_FN, dead: 1'b0, evt_cyc: 419, golden_en: 1'b1, golden: 32'h534EAA58};
    vecs[1] = '{kc: 64'h0, fn: 22'h0, dead: 1'b0, evt_cyc: 419, golden_en: 1'b0, golden: 32'h0};
    vecs[2] = '{kc: '1, fn: 22'h3FFFFF, dead: 1'b0, evt_cyc: 419, golden_en: 1'b0, golden: 32'h0};
    vecs[3] = '{kc: 64'h0123456789ABCDEF, fn: 22'h2AAAAA, dead: 1'b0, evt_cyc: 419, golden_en: 1'b0, golden: 32'h0};
    vecs[4] = '{kc: 64'hDEADBEEFCAFEF00D, fn: 22'h1, dead: 1'b1, evt_cyc: 209, golden_en: 1'b0, golden: 32'h0};
    vecs[5] = '{kc: REF_KC, fn: REF_FN, dead: 1'b0, evt_cyc: 419, golden_en: 1'b1, golden: 32'h534EAA58};

    // Reset state
    Reset = 1'b1;
    Start = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 228'(Busy), 228'(0));
    chk("rst_done", 228'(Done), 228'(0));
    chk("rst_error", 228'(Error), 228'(0));
    chk("rst_ks_dl", 228'(Ks_dl), 228'(0));
    chk("rst_ks_ul", 228'(Ks_ul), 228'(0));
    chk("rst_core_reset_n", 228'(Core_Reset_n), 228'(0));
    chk("rst_startloading", 228'(Core_Startloading), 228'(0));
    chk("rst_keybit", 228'(Core_Keybit), 228'(0));
    Reset = 1'b0;
    Start = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i == 0);

    // Start held high for cycles 0..499: one run, then a second from cycle 420.
    Kc        = REF_KC;
    Fn        = REF_FN;
    core_dead = 1'b0;
    a5_ref(REF_KC, REF_FN, e2.dl, e2.ul);
    e2.err = 1'b0;
    e2.cyc = 419;
    sb.push_back(e2);
    e2.cyc = 839;
    sb.push_back(e2);
    cyc   = 0;
    Start = 1'b1;
    for (int n = 0; n < 1200 && sb.size() != 0; n++) begin
      tick();
      Start = (cyc < 500);
    end
    Start = 1'b0;
    drain(1);
    repeat (4) tick();

    // Reset during COLLECT aborts the run; a later Start runs cleanly.
    cyc   = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    while (cyc < 200) tick();
    Reset = 1'b1;
    #1;
    chk("midrun_reset_core_reset_n", 228'(Core_Reset_n), 228'(0));
    tick();
    Reset = 1'b0;
    chk("abort_busy", 228'(Busy), 228'(0));
    chk("abort_done", 228'(Done), 228'(0));
    chk("abort_error", 228'(Error), 228'(0));
    chk("abort_ks_dl", 228'(Ks_dl), 228'(0));
    chk("abort_ks_ul", 228'(Ks_ul), 228'(0));
    chk("abort_startloading", 228'(Core_Startloading), 228'(0));
    chk("abort_keybit", 228'(Core_Keybit), 228'(0));
    while (cyc < 205) tick();
    e2.cyc = 624;
    sb.push_back(e2);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    drain(1000);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
